// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS fetch types, opcodes and instruction field positions
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int JTGT_MSB = 25;
  localparam int JTGT_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // Branch displacement in bytes: sign-extended word offset scaled by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection (jump over taken branch over pc+4)
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [JTGT_MSB:0] instr,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [31:0]       next_pc
);

  logic [31:0] pc4;

  always_comb begin
    pc4 = pc + 32'd4;
    if (jump) begin
      next_pc = {pc4[31:28], instr[JTGT_MSB:JTGT_LSB], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC register, imem req/ack, instr to decoder (option: FETCH_TIMEOUT_EN)
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic        fetch_err
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic [31:0]  next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
  end
`endif

  next_pc_calc u_next_pc (
    .pc      (pc_q),
    .instr   (instr_q[JTGT_MSB:0]),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_VALID: begin
        // Control inputs are consumed only here, on the retiring cycle.
        if (!stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ST_ERR: begin
        state_d = ST_ERR;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign pc          = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a program-level PC model
module tb_instr_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic        fetch_err;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc = 32'h0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .stall       (stall),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule stated with plain integer arithmetic.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] word,
                                                input bit br, input bit j, input bit z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    if (br && z) begin
      off = $signed(word[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    tick();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_op", 32'(op), 32'(OP_RTYPE));
    check_eq("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_seen", 32'(imem_req), 32'd1);
  endtask

  task automatic step(input logic [31:0] word, input int delay, input int stalls,
                      input bit br, input bit j, input bit z);
    wait_req();
    check_eq("fetch_addr", imem_addr, exp_pc);
    check_eq("fetch_valid_low", 32'(instr_valid), 32'd0);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      tick();
      check_eq("req_hold", 32'(imem_req), 32'd1);
    end
    imem_ack = 1'b1; imem_rdata = word; stall = 1'b1;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    check_eq("valid_set", 32'(instr_valid), 32'd1);
    check_eq("instr", instr, word);
    check_eq("op", 32'(op), word >> 26);
    check_eq("pc_at_valid", pc, exp_pc);
    check_eq("req_drop", 32'(imem_req), 32'd0);
    for (int i = 0; i < stalls; i++) begin
      branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      tick();
      check_eq("stall_instr", instr, word);
      check_eq("stall_pc", pc, exp_pc);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_no_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0; stall = 1'b0; branch = br; jump = j; zero = z;
    tick();
    stall = 1'b1; branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
    exp_pc = model_next_pc(exp_pc, word, br, j, z);
    check_eq("retire_valid_low", 32'(instr_valid), 32'd0);
    check_eq("retire_pc", pc, exp_pc);
    check_eq("retire_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] jmax;
    int          sel;

    jmax = {OP_J, 26'h3FF_FFFF};
    do_reset();

    tick();
    check_eq("t1_req_cycle2", 32'(imem_req), 32'd1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    step(32'h8C08_0004, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_pc4", pc, 32'h4);
    step({OP_ADDI, 26'h0}, 0, 3, 1'b0, 1'b0, 1'b0);
    check_eq("t2_pc8", pc, 32'h8);

    step(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b1);
    check_eq("t3_beq_taken", pc, 32'h4);
    step({OP_RTYPE, 26'h0}, 0, 0, 1'b0, 1'b0, 1'b0);
    step(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("t3_beq_not_taken", pc, 32'hC);

    step(jmax, 0, 0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_jump_edge", pc, 32'h0FFF_FFFC);
    step({OP_SW, 26'h0}, 0, 0, 1'b0, 1'b0, 1'b0);
    step(32'h0800_0040, 0, 1, 1'b1, 1'b1, 1'b1);
    check_eq("t4_jump_wins", pc, 32'h1000_0100);

    for (int r = 1; r < 16; r++) begin
      step(jmax, $urandom_range(0, 2), 0, 1'b0, 1'b1, 1'b0);
      step({OP_LW, 26'($urandom)}, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("wrap_to_zero", pc, 32'h0);

    wait_req();
    imem_ack = 1'b1; imem_rdata = $urandom; rst_n = 1'b0;
    tick();
    imem_ack = 1'b0;
    check_eq("t5_req", 32'(imem_req), 32'd0);
    check_eq("t5_valid", 32'(instr_valid), 32'd0);
    check_eq("t5_instr", instr, 32'h0);
    check_eq("t5_pc", pc, 32'h0);
    rst_n = 1'b1; exp_pc = 32'h0;

    step({OP_BEQ, 26'h0}, 0, 0, 1'b0, 1'b0, 1'b0);
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("rst_stall_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_stall_pc", pc, 32'h0);
    check_eq("rst_stall_instr", instr, 32'h0);
    rst_n = 1'b1; stall = 1'b0; exp_pc = 32'h0;

    wait_req();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check_eq("to_req_before", 32'(imem_req), 32'd1);
    check_eq("to_err_before", 32'(fetch_err), 32'd0);
    tick();
    check_eq("to_err_set", 32'(fetch_err), 32'd1);
    check_eq("to_req_drop", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; imem_rdata = $urandom;
    for (int i = 0; i < 3; i++) tick();
    imem_ack = 1'b0;
    check_eq("to_err_sticky", 32'(fetch_err), 32'd1);
    check_eq("to_ack_ignored", 32'(instr_valid), 32'd0);
    check_eq("to_req_stays_low", 32'(imem_req), 32'd0);
`else
    for (int i = 0; i < 40; i++) tick();
    check_eq("wait_req_held", 32'(imem_req), 32'd1);
    check_eq("wait_err_tied", 32'(fetch_err), 32'd0);
    check_eq("wait_no_valid", 32'(instr_valid), 32'd0);
`endif
    do_reset();

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       w = {OP_BEQ, 10'($urandom), 16'($urandom)};
        1:       w = {OP_J, 26'($urandom)};
        2:       w = {OP_LW, 26'($urandom)};
        default: w = $urandom;
      endcase
      step(w, $urandom_range(0, 3), $urandom_range(0, 2),
           1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the single-cycle MIPS datapath. It sits directly upstream of the main control decoder.
- Owns the PC register.
- Fetches one word per instruction from instruction memory over a req/ack handshake.
- Presents the instruction and its opcode field (instr[31:26]) to the decoder.
- Computes the next PC from the Branch/Jump/Zero results returned by control and the ALU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
TIMEOUT_CYCLES, 16, max cycles waiting for imem_ack (used only with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  instruction word; valid when imem_ack=1
imem_ack  in  1  memory completes fetch this cycle
instr_valid  out  1  instr/op/pc hold a fetched instruction
instr  out  32  registered instruction word
op  out  6  instr[31:26], to control decoder
pc  out  32  address of current instruction
stall  in  1  downstream not ready; instruction must not retire
branch  in  1  Branch from control decoder
jump  in  1  Jump from control decoder
zero  in  1  ALU zero flag
fetch_err  out  1  sticky fetch timeout (FETCH_TIMEOUT_EN only; else tied 0)

Behaviour:
- Clocking: all state updates on the rising clk edge. rst_n is synchronous and active-low; rst_n=0 has priority over every other event.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0.
- States:
  - IDLE: imem_req=0. Go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, capture imem_rdata into instr, set instr_valid=1 and go to VALID. Otherwise stay in FETCH.
  - VALID: instr_valid=1; instr, op and pc are stable.
    - Retire = instr_valid & ~stall. On retire, pc <= next_pc, instr_valid <= 0, go to FETCH.
    - If stall=1, hold everything.
- next_pc rules (combinational, from current pc and instr):
  - pc4 = pc + 4.
  - jump=1: {pc4[31:28], instr[25:0], 2'b00}.
  - else branch & zero: pc4 + (sign_extend(instr[15:0]) << 2).
  - else: pc4.
  - jump has priority over branch.
- Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC with no branch/jump wraps to 0. pc[1:0] is always 00.
- Handshake details:
  - imem_ack outside FETCH is ignored.
  - imem_rdata is sampled only on the ack cycle.
  - imem_req must not drop before ack.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then VALID with stall=0).
- branch/jump/zero are sampled only on the retire cycle.
- op is always instr[31:26]; it reads 0 (R-type encoding) after reset but is only meaningful while instr_valid=1.
- Reset asserted mid-fetch or mid-stall: the next cycle is IDLE with reset values. Any ack arriving during reset is discarded.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, set fetch_err=1 (sticky until reset), drop imem_req and enter ERR.
  - ERR is absorbing; instr_valid=0 while in ERR.
- Undefined: no counter and no ERR state; fetch_err is tied 0 and FETCH waits indefinitely.

Decomposition:
- Shared package mips_pkg:
  - fetch state enum (IDLE, FETCH, VALID, ERR).
  - opcode constants: R-type 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010.
  - default RESET_PC, and the instruction field positions (op, jump target, immediate).
- Sub-module next_pc_calc (combinational): pc, instr, branch, jump, zero -> next_pc. It is unit-testable on its own.

Test Plan:
1. Reset then ack on first FETCH cycle with rdata=32'h8C08_0004: imem_req high in cycle 2 with imem_addr=0; instr_valid=1 next cycle; op=6'b100011.
2. Retire with stall=0, branch=0, jump=0 -> pc=4, next imem_addr=4; then stall=1 for 3 cycles -> instr/pc held, no imem_req.
3. pc=8, instr=32'h1000_FFFE (BEQ, imm=-2), branch=1, zero=1 -> pc=4. Same with zero=0 -> pc=12.
4. pc=32'h1000_0000, instr=32'h0800_0040, jump=1, branch=1, zero=1 -> pc=32'h1000_0100 (jump wins).
5. rst_n=0 while in FETCH with ack asserted the same cycle -> next cycle state=IDLE, pc=RESET_PC, instr_valid=0, instr=0.
6. FETCH_TIMEOUT_EN defined, ack never asserted -> fetch_err=1 after 16 FETCH cycles, imem_req=0 thereafter; later ack has no effect.
